// File: rtl/fadd32_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : fadd32_rr_sched
// Description : Round-robin scheduler sharing one FP32 adder among NUM_REQ
//               requesters. Operands are registered into the adder, a tag
//               pipeline matched to ADD_LAT tracks in-flight work, and results
//               land in a credit-protected response FIFO in issue order.
//               Optional macro FADD32_SCHED_STATS_EN adds busy/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fadd32_rr_sched #(
    parameter  int NUM_REQ    = 4,
    parameter  int ADD_LAT    = 0,
    parameter  int FIFO_DEPTH = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    input  logic [31:0]           add_o,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id
`ifdef FADD32_SCHED_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [31:0]           stat_busy,
    output logic [31:0]           stat_stall
`endif
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [ID_W-1:0]    r_ptr;
    logic [c_CNT_W-1:0] r_inflight;
    logic [c_CNT_W-1:0] r_fifo_cnt;
    logic               w_can_issue;
    logic               w_grant_vld;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_accept;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic [31:0]        r_add_a;
    logic [31:0]        r_add_b;
    logic               r_tag_vld [0:ADD_LAT];
    logic [ID_W-1:0]    r_tag_id  [0:ADD_LAT];
    logic               w_push;
    logic               w_pop;
    logic [31:0]        r_mem_data [0:FIFO_DEPTH-1];
    logic [ID_W-1:0]    r_mem_id   [0:FIFO_DEPTH-1];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // A credit is held from accept until the result leaves the FIFO.
    assign w_can_issue = ({1'b0, r_inflight} + {1'b0, r_fifo_cnt}) <
                         (c_CNT_W + 1)'(FIFO_DEPTH);

    always_comb begin : p_arb
        logic [ID_W-1:0] w_scan_idx;
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_scan_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_scan_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_grant_vld && req_valid[w_scan_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_scan_idx;
            end
        end
    end

    assign w_accept = w_grant_vld & w_can_issue;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_accept && (w_grant_id == ID_W'(i));
        end
    end

    assign w_sel_a = req_a[32*w_grant_id +: 32];
    assign w_sel_b = req_b[32*w_grant_id +: 32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= ID_W'(NUM_REQ - 1);
            r_add_a <= '0;
            r_add_b <= '0;
        end else if (w_accept) begin
            r_ptr   <= w_grant_id;
            r_add_a <= w_sel_a;
            r_add_b <= w_sel_b;
        end
    end

    assign add_a = r_add_a;
    assign add_b = r_add_b;

    // Free-running tag shift: credits already reserved FIFO space.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= ADD_LAT; s++) begin
                r_tag_vld[s] <= 1'b0;
                r_tag_id[s]  <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_accept;
            r_tag_id[0]  <= w_grant_id;
            for (int s = ADD_LAT; s >= 1; s--) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
        end
    end

    assign w_push = r_tag_vld[ADD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_push})
                2'b10:   r_inflight <= r_inflight + c_CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - c_CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign rsp_valid = (r_fifo_cnt != '0);
    assign w_pop     = rsp_valid & rsp_ready;
    assign rsp_data  = r_mem_data[r_rd_ptr];
    assign rsp_id    = r_mem_id[r_rd_ptr];

    // At full with a pop, wr_ptr == rd_ptr: the departing head slot is reused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_id[i]   <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= add_o;
                r_mem_id[r_wr_ptr]   <= r_tag_id[ADD_LAT];
                r_wr_ptr             <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

`ifdef FADD32_SCHED_STATS_EN
    logic [31:0] r_stat_busy;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_busy  <= '0;
            r_stat_stall <= '0;
        end else if (stat_clr) begin
            r_stat_busy  <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_accept && (r_stat_busy != 32'hFFFF_FFFF)) begin
                r_stat_busy <= r_stat_busy + 32'd1;
            end
            if ((|req_valid) && !w_can_issue && (r_stat_stall != 32'hFFFF_FFFF)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_busy  = r_stat_busy;
    assign stat_stall = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fadd32_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_fadd32_rr_sched
// Description : Scoreboard bench for fadd32_rr_sched with a 2-stage adder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fadd32_rr_sched;

    localparam int NR    = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [32*NR-1:0]  req_a;
    logic [32*NR-1:0]  req_b;
    logic [31:0]       add_a;
    logic [31:0]       add_b;
    logic [31:0]       add_o;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [IDW-1:0]    rsp_id;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    data;
    } exp_t;
    exp_t sb_q[$];

    initial forever #5 clk = ~clk;

    fadd32_rr_sched #(
        .NUM_REQ    (NR),
        .ADD_LAT    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_o     (add_o),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    // External adder: real sums for the hand vectors, non-commutative mix otherwise.
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40A0_0000;
        return a + (b << 1);
    endfunction

    logic [31:0] r_s1;
    logic [31:0] r_s2;
    always @(posedge clk) begin
        r_s1 <= model_add(add_a, add_b);
        r_s2 <= r_s1;
    end
    assign add_o = r_s2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue side: record every accept into the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst_n && ((req_valid & req_ready) != '0)) begin
            check("grant_onehot", 32'($onehot(req_ready)), 32'd1);
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back({IDW'(i), model_add(req_a[32*i +: 32], req_b[32*i +: 32])});
                end
            end
            n_acc++;
        end
    end

    // Response side: pop and compare on every handshake.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_id", 32'(rsp_id), 32'(e.id));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic set_stream(input int seed);
        for (int i = 0; i < NR; i++) begin
            set_lane(i, {8'h40, 8'(i), 16'(seed)}, {8'h3F, 8'(seed), 8'h00, 8'(i)});
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        rsp_ready = 1'b1;
        while ((sb_q.size() != 0 || rsp_valid) && c < 40) begin
            step();
            c++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_rsp(input string name);
        int c;
        c = 0;
        @(negedge clk);
        while (!rsp_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        int a0;
        int c;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_add_a", add_a, 32'd0);
        check("rst_add_b", add_b, 32'd0);
        rst_n = 1'b1;
        step();

        // Basic issue: 1.0 + 2.0 from requester 2
        set_lane(2, 32'h3F80_0000, 32'h4000_0000);
        req_valid = 4'b0100;
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        check("t1_add_a", add_a, 32'h3F80_0000);
        check("t1_add_b", add_b, 32'h4000_0000);
        step();
        check("t1_lat1", 32'(rsp_valid), 32'd0);
        step();
        check("t1_lat2", 32'(rsp_valid), 32'd0);
        step();
        check("t1_lat3", 32'(rsp_valid), 32'd1);
        check("t1_data", rsp_data, 32'h4040_0000);
        check("t1_id", 32'(rsp_id), 32'd2);
        step();
        check("t1_popped", 32'(rsp_valid), 32'd0);

        // 2.0 + 3.0 from requester 1
        set_lane(1, 32'h4000_0000, 32'h4040_0000);
        req_valid = 4'b0010;
        @(negedge clk);
        check("t1b_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        wait_rsp("t1b_rsp");
        check("t1b_data", rsp_data, 32'h40A0_0000);
        check("t1b_id", 32'(rsp_id), 32'd1);
        drain();

        // Round-robin from reset: requester 0 first
        rst_n = 1'b0;
        sb_q.delete();
        step();
        rst_n = 1'b1;
        set_stream(1);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            c = 0;
            @(negedge clk);
            while (req_ready == '0 && c < 8) begin
                step();
                @(negedge clk);
                c++;
            end
            check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            step();
            set_stream(k + 2);
        end
        req_valid = '0;
        drain();

        // Backpressure: requester 1 streams into a stalled consumer
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        a0 = n_acc;
        for (int k = 0; k < 12; k++) begin
            step();
            set_stream(20 + k);
        end
        check("bp_accepts", 32'(n_acc - a0), 32'd4);
        @(negedge clk);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        step();
        rsp_ready = 1'b1;
        a0 = n_acc;
        step();
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_one_ready", 32'(req_ready), 32'h2);
        step();
        set_stream(40);
        step();
        set_stream(41);
        check("bp_single", 32'(n_acc - a0), 32'd1);
        step();
        set_stream(42);
        // Next edge pushes the lone in-flight result while popping the head.
        check("pp_valid_pre", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            set_stream(43 + k);
        end
        req_valid = '0;
        drain();

        // Eight back-to-back ops on the 2-stage adder
        req_valid = 4'b1000;
        set_stream(100);
        a0 = n_acc;
        @(negedge clk);
        check("s8_first_ready", 32'(req_ready), 32'h8);
        step();
        set_stream(101);
        step();
        set_stream(102);
        check("s8_lat1", 32'(rsp_valid), 32'd0);
        step();
        set_stream(103);
        check("s8_lat2", 32'(rsp_valid), 32'd0);
        step();
        set_stream(104);
        check("s8_lat3", 32'(rsp_valid), 32'd1);
        c = 0;
        while ((n_acc - a0) < 8 && c < 20) begin
            step();
            set_stream(105 + c);
            c++;
        end
        req_valid = '0;
        check("s8_count", 32'(n_acc - a0), 32'd8);
        drain();

        // Reset with two ops in flight and two queued
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        set_stream(200);
        a0 = n_acc;
        c = 0;
        while ((n_acc - a0) < 4 && c < 20) begin
            step();
            set_stream(201 + c);
            c++;
        end
        req_valid = '0;
        check("mf_accepts", 32'(n_acc - a0), 32'd4);
        step();
        check("mf_setup_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mf_rst_valid", 32'(rsp_valid), 32'd0);
        check("mf_rst_data", rsp_data, 32'd0);
        sb_q.delete();
        step();
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("mf_no_rsp", 32'(rsp_valid), 32'd0);
        end
        req_valid = 4'b1111;
        set_stream(300);
        @(negedge clk);
        check("mf_first_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        wait_rsp("mf_new_rsp");
        drain();

        check("final_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
